ms_timer: RTL and testbench

- Millisecond timebase peripheral for the ZPU system bus.
- Consumes the 1 kHz square wave from the clock divider stage and synchronises it into sys_clk.
- Edge-detects that wave into a one-cycle tick; each tick is one millisecond.
- Maintains a free-running 32-bit millisecond counter plus a programmable countdown with a level interrupt, all accessible through a small register interface.

---
 rtl/ms_timer.sv | 122 ++++++++++++
 tb/tb_ms_timer.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/ms_timer.sv
// Millisecond timebase: synchronises the 1 kHz divider output into sys_clk,
// counts milliseconds and runs a reloadable countdown with a level interrupt.
module ms_timer #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 32
) (
  input  logic             sys_clk,
  input  logic             rst,
  input  logic             khz_clk,
  input  logic [1:0]       addr,
  input  logic             wr,
  input  logic             rd,
  input  logic [CNT_W-1:0] wdata,
  output logic [CNT_W-1:0] rdata,
  output logic             tick,
  output logic             irq
);

  localparam logic [1:0]       A_COUNT  = 2'd0;
  localparam logic [1:0]       A_RELOAD = 2'd1;
  localparam logic [1:0]       A_CTRL   = 2'd2;
  localparam logic [1:0]       A_STATUS = 2'd3;
  localparam logic [CNT_W-1:0] ONE      = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [SYNC_STAGES-1:0] khz_sync_p0;
  logic                   khz_hist_p1;

  logic [CNT_W-1:0] ms_count;
  logic [CNT_W-1:0] reload;
  logic [CNT_W-1:0] down;
  logic             enable;
  logic             irq_en;
  logic             periodic;
  logic             pending;

  logic wr_count;
  logic wr_reload;
  logic wr_ctrl;
  logic wr_status;
  logic running;
  logic expire;

  // Stage p0: synchroniser chain; stage p1: history flop and registered rising-edge tick
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      khz_sync_p0 <= '0;
      khz_hist_p1 <= 1'b0;
      tick        <= 1'b0;
    end else begin
      khz_sync_p0 <= {khz_sync_p0[SYNC_STAGES-2:0], khz_clk};
      khz_hist_p1 <= khz_sync_p0[SYNC_STAGES-1];
      tick        <= khz_sync_p0[SYNC_STAGES-1] & ~khz_hist_p1;
    end
  end

  assign wr_count  = wr && (addr == A_COUNT);
  assign wr_reload = wr && (addr == A_RELOAD);
  assign wr_ctrl   = wr && (addr == A_CTRL);
  assign wr_status = wr && (addr == A_STATUS);
  assign running   = tick && enable && (down != '0);
  assign expire    = running && (down == ONE);

  // Register stage: counter, countdown and bus-visible state
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      ms_count <= '0;
      reload   <= '0;
      down     <= '0;
      enable   <= 1'b0;
      irq_en   <= 1'b0;
      periodic <= 1'b0;
      pending  <= 1'b0;
      rdata    <= '0;
    end else begin
      if (wr_count)
        ms_count <= wdata;
      else if (tick)
        ms_count <= ms_count + ONE;

      if (wr_reload)
        reload <= wdata;

      // A CTRL write overrides whatever the expiring tick would have done to down/enable
      if (wr_ctrl) begin
        enable   <= wdata[0];
        irq_en   <= wdata[1];
        periodic <= wdata[2];
        if (wdata[0])
          down <= reload;
      end else if (running) begin
        if (expire) begin
          if (periodic) begin
            down <= reload;
          end else begin
            down   <= '0;
            enable <= 1'b0;
          end
        end else begin
          down <= down - ONE;
        end
      end

      if (expire)
        pending <= 1'b1;
      else if (wr_status && wdata[0])
        pending <= 1'b0;

      // Reads sample the state before any same-cycle write lands
      if (rd) begin
        case (addr)
          A_COUNT:  rdata <= ms_count;
          A_RELOAD: rdata <= reload;
          A_CTRL:   rdata <= {{(CNT_W-3){1'b0}}, periodic, irq_en, enable};
          default:  rdata <= {down[CNT_W-2:0], pending};
        endcase
      end
    end
  end

  assign irq = pending & irq_en;

endmodule

// File: tb/tb_ms_timer.sv
// Bench for ms_timer: register reads are scored through an expected-value queue,
// tick/irq levels are compared directly against values derived from the register model.
module tb_ms_timer;

  localparam int CNT_W = 32;

  logic             sys_clk = 1'b0;
  logic             rst     = 1'b1;
  logic             khz_clk = 1'b0;
  logic [1:0]       addr    = 2'd0;
  logic             wr      = 1'b0;
  logic             rd      = 1'b0;
  logic [CNT_W-1:0] wdata   = '0;
  logic [CNT_W-1:0] rdata;
  logic             tick;
  logic             irq;

  int          n_checks = 0;
  int          n_fails  = 0;
  int          tick_cnt = 0;
  int          tick_base;
  logic        rd_q     = 1'b0;
  logic [31:0] exp_q[$];
  string       tag_q[$];

  ms_timer #(.SYNC_STAGES(2), .CNT_W(CNT_W)) dut (
    .sys_clk (sys_clk),
    .rst     (rst),
    .khz_clk (khz_clk),
    .addr    (addr),
    .wr      (wr),
    .rd      (rd),
    .wdata   (wdata),
    .rdata   (rdata),
    .tick    (tick),
    .irq     (irq)
  );

  always #10 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Read data is due on the negedge following the edge that sampled rd
  always @(posedge sys_clk) rd_q <= rd;

  always @(negedge sys_clk) begin
    if (tick === 1'b1) tick_cnt++;
    if (rd_q) begin
      check("sb_depth", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) check(tag_q.pop_front(), rdata, exp_q.pop_front());
    end
  end

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic reg_wr(input logic [1:0] a, input logic [31:0] d);
    wr = 1'b1; addr = a; wdata = d;
    step();
    wr = 1'b0;
  endtask

  task automatic reg_rd(input logic [1:0] a, input logic [31:0] exp, input string tag);
    rd = 1'b1; addr = a;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    step();
    rd = 1'b0;
  endtask

  // One 40-cycle khz_clk period. khz_clk rises just after an edge, so the next edge
  // samples it; tick is high after the third edge counting that sampling edge.
  // Optionally a register write is placed in the cycle where tick is high.
  task automatic khz_pulse(input logic do_wr, input logic [1:0] a, input logic [31:0] d);
    khz_clk = 1'b1;
    step(); check("tick_lat_e1", 32'(tick), 32'd0);
    step(); check("tick_lat_e2", 32'(tick), 32'd0);
    step(); check("tick_lat_e3", 32'(tick), 32'd1);
    if (do_wr) begin
      wr = 1'b1; addr = a; wdata = d;
    end
    step();
    wr = 1'b0;
    check("tick_width", 32'(tick), 32'd0);
    repeat (16) step();
    khz_clk = 1'b0;
    repeat (20) step();
  endtask

  task automatic ticks(input int n);
    repeat (n) khz_pulse(1'b0, 2'd0, 32'd0);
  endtask

  initial begin
    step();
    check("rst_rdata", rdata, 32'd0);
    check("rst_tick", 32'(tick), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    rst = 1'b0;
    repeat (2) step();

    // Free-running count from reset
    tick_base = tick_cnt;
    ticks(10);
    check("tick_count_10", 32'(tick_cnt - tick_base), 32'd10);
    reg_rd(2'd0, 32'd10, "ms_count_10");

    // Wrap
    reg_wr(2'd0, 32'hFFFF_FFFE);
    ticks(1); reg_rd(2'd0, 32'hFFFF_FFFF, "wrap_ffffffff");
    ticks(1); reg_rd(2'd0, 32'h0000_0000, "wrap_0");
    ticks(1); reg_rd(2'd0, 32'h0000_0001, "wrap_1");

    // One-shot, reload 5
    reg_wr(2'd1, 32'd5);
    reg_wr(2'd2, 32'b011);
    for (int i = 1; i <= 4; i++) begin
      ticks(1);
      check("oneshot_irq_early", 32'(irq), 32'd0);
    end
    reg_rd(2'd3, 32'd2, "oneshot_status_t4");
    ticks(1);
    check("oneshot_irq_t5", 32'(irq), 32'd1);
    reg_rd(2'd2, 32'b010, "oneshot_ctrl");
    reg_rd(2'd3, 32'd1, "oneshot_status_t5");
    ticks(2);
    reg_rd(2'd3, 32'd1, "oneshot_hold");

    // Periodic, reload 3, cleared after each expiry
    reg_wr(2'd3, 32'd1);
    check("status_clear", 32'(irq), 32'd0);
    reg_wr(2'd1, 32'd3);
    reg_wr(2'd2, 32'b111);
    for (int t = 1; t <= 9; t++) begin
      ticks(1);
      check("periodic_irq", 32'(irq), 32'((t % 3) == 0));
      if ((t % 3) == 0) begin
        reg_wr(2'd3, 32'd1);
        check("periodic_clr", 32'(irq), 32'd0);
      end
    end
    reg_wr(2'd2, 32'b101);
    ticks(3);
    check("masked_irq", 32'(irq), 32'd0);
    reg_rd(2'd3, 32'd7, "masked_status");

    // Expiry coinciding with a STATUS clear: set wins
    reg_wr(2'd3, 32'd1);
    reg_wr(2'd1, 32'd2);
    reg_wr(2'd2, 32'b011);
    ticks(1);
    khz_pulse(1'b1, 2'd3, 32'd1);
    reg_rd(2'd3, 32'd1, "set_wins_status");
    check("set_wins_irq", 32'(irq), 32'd1);

    // Expiry coinciding with a CTRL write: restart from reload, pending still sets
    reg_wr(2'd3, 32'd1);
    reg_wr(2'd2, 32'b011);
    ticks(1);
    khz_pulse(1'b1, 2'd2, 32'b011);
    reg_rd(2'd3, 32'd5, "ctrl_wins_status");

    // MS_COUNT write in a tick cycle: write wins
    khz_pulse(1'b1, 2'd0, 32'h100);
    reg_rd(2'd0, 32'h100, "count_wr_wins");

    // Asynchronous reset mid-count
    reg_wr(2'd1, 32'd4);
    reg_wr(2'd2, 32'b011);
    ticks(2);
    check("pre_rst_irq", 32'(irq), 32'd1);
    #3 rst = 1'b1;
    #1;
    check("async_rst_irq", 32'(irq), 32'd0);
    check("async_rst_rdata", rdata, 32'd0);
    #3 rst = 1'b0;
    step();
    tick_base = tick_cnt;
    repeat (30) step();
    check("no_tick_after_rst", 32'(tick_cnt - tick_base), 32'd0);
    reg_rd(2'd0, 32'd0, "rst_ms_count");
    reg_rd(2'd1, 32'd0, "rst_reload");
    reg_rd(2'd2, 32'd0, "rst_ctrl");
    reg_rd(2'd3, 32'd0, "rst_status");
    ticks(1);
    check("tick_after_rst", 32'(tick_cnt - tick_base), 32'd1);
    reg_rd(2'd0, 32'd1, "count_after_rst");
    reg_rd(2'd3, 32'd0, "status_after_rst");

    repeat (2) step();
    check("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
